// File: rtl/tri_pkg.sv
// ============================================================================
//  Module      : tri_pkg
//  Description : Shared types and width-derivation helpers for the
//                triangle hit scanner (FSM state encoding, coordinate and
//                triangle record layouts, datapath width functions).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tri_pkg;

  // Scanner control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest supported coordinate; narrower coordinates sign-extend into it.
  localparam int MAX_COORD_W = 16;
  localparam int NUM_VERTS   = 3;
  localparam int NUM_FIELDS  = 2 * NUM_VERTS;

  typedef logic signed [MAX_COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef struct packed {
    point_t p1;
    point_t p2;
    point_t p3;
  } tri_t;

  function automatic int tri_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Difference of two signed coordinates needs one extra bit.
  function automatic int tri_diff_w(input int cw);
    return cw + 1;
  endfunction

  // Product of two differences.
  function automatic int tri_prod_w(input int cw);
    return 2 * cw + 2;
  endfunction

  // Difference of two products: one more bit keeps it exact.
  function automatic int tri_edge_w(input int cw);
    return 2 * cw + 3;
  endfunction

  // LSB of a coordinate field in the packed {P1X,P1Y,P2X,P2Y,P3X,P3Y} word;
  // field 0 is P1X (most significant).
  function automatic int tri_field_lsb(input int field, input int cw);
    return (NUM_FIELDS - 1 - field) * cw;
  endfunction

endpackage : tri_pkg

`default_nettype wire

// File: rtl/tri_edge_eval.sv
// ============================================================================
//  Module      : tri_edge_eval
//  Description : Two-stage pipelined edge function
//                  e(A,B) = (PX-BX)*(AY-BY) - (AX-BX)*(PY-BY)
//                Stage 1 registers the four differences, stage 2 registers
//                the exact signed result.
//  Ports       : clk          - clock
//                i_px, i_py   - query point (signed COORD_W)
//                i_ax, i_ay   - edge start vertex A (signed COORD_W)
//                i_bx, i_by   - edge end vertex B (signed COORD_W)
//                o_e          - registered e, signed 2*COORD_W+3 bits
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tri_edge_eval
  import tri_pkg::*;
#(
  parameter  int COORD_W = 12,
  localparam int EDGE_W  = tri_edge_w(COORD_W)
) (
  input  logic               clk,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  output logic [EDGE_W-1:0]  o_e
);

  localparam int DIFF_W = tri_diff_w(COORD_W);
  localparam int PROD_W = tri_prod_w(COORD_W);

  logic signed [DIFF_W-1:0] r_dpx, r_day, r_dax, r_dpy;
  logic signed [PROD_W-1:0] w_prod_a, w_prod_b;
  logic signed [EDGE_W-1:0] w_e;

  // Stage 1: sign-extend by one bit so the differences are exact.
  always_ff @(posedge clk) begin
    r_dpx <= {i_px[COORD_W-1], i_px} - {i_bx[COORD_W-1], i_bx};
    r_day <= {i_ay[COORD_W-1], i_ay} - {i_by[COORD_W-1], i_by};
    r_dax <= {i_ax[COORD_W-1], i_ax} - {i_bx[COORD_W-1], i_bx};
    r_dpy <= {i_py[COORD_W-1], i_py} - {i_by[COORD_W-1], i_by};
  end

  // Stage 2: operands are widened (signed) before multiplying.
  assign w_prod_a = PROD_W'(r_dpx) * PROD_W'(r_day);
  assign w_prod_b = PROD_W'(r_dax) * PROD_W'(r_dpy);
  assign w_e      = EDGE_W'(w_prod_a) - EDGE_W'(w_prod_b);

  always_ff @(posedge clk) begin
    o_e <= w_e;
  end

endmodule : tri_edge_eval

`default_nettype wire

// File: rtl/tri_hit_scanner.sv
// ============================================================================
//  Module      : tri_hit_scanner
//  Description : Point-in-triangle scanner. Holds a table of NUM_TRI
//                triangles; each accepted query point is tested against
//                every valid entry (one entry per cycle through a 2-stage
//                edge pipeline) and a hit mask plus lowest-hit index is
//                returned over a valid/ready handshake.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                tri_we/waddr/wdata  - table write {P1X,P1Y,P2X,P2Y,P3X,P3Y}
//                tri_clr             - clear all entry-valid bits
//                q_valid/q_ready     - query handshake, q_x/q_y query point
//                r_valid/r_ready     - result handshake
//                r_hit_mask, r_any, r_first - result
//                busy                - high whenever not IDLE
//  Config      : TRI_EDGE_EXCL_EN - when defined, points exactly on an edge
//                miss (strict inequalities); default is edge-inclusive.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tri_hit_scanner
  import tri_pkg::*;
#(
  parameter  int COORD_W = 12,
  parameter  int NUM_TRI = 4,
  localparam int IDX_W   = tri_idx_w(NUM_TRI)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tri_we,
  input  logic [IDX_W-1:0]          tri_waddr,
  input  logic [NUM_FIELDS*COORD_W-1:0] tri_wdata,
  input  logic                      tri_clr,
  input  logic                      q_valid,
  output logic                      q_ready,
  input  logic [COORD_W-1:0]        q_x,
  input  logic [COORD_W-1:0]        q_y,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [NUM_TRI-1:0]        r_hit_mask,
  output logic                      r_any,
  output logic [IDX_W-1:0]          r_first,
  output logic                      busy
);

  localparam int ENTRY_W = NUM_FIELDS * COORD_W;
  localparam int EDGE_W  = tri_edge_w(COORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRI - 1);

  state_e             r_state;
  logic [ENTRY_W-1:0] r_table [NUM_TRI];
  logic [NUM_TRI-1:0] r_ent_vld;
  logic [COORD_W-1:0] r_qx, r_qy;
  logic [IDX_W-1:0]   r_idx;
  logic               r_issuing;
  logic               r_s1_vld, r_s1_ev, r_s2_vld, r_s2_ev;
  logic [IDX_W-1:0]   r_s1_idx, r_s2_idx;

  logic [NUM_TRI-1:0] w_ent_vld_next;
  logic [ENTRY_W-1:0] w_entry;
  logic [COORD_W-1:0] w_vx [NUM_VERTS];
  logic [COORD_W-1:0] w_vy [NUM_VERTS];
  logic [EDGE_W-1:0]  w_e  [NUM_VERTS];
  logic [NUM_VERTS-1:0] w_pos, w_neg, w_zero;
  logic               w_geom_hit, w_hit;
  logic [NUM_TRI-1:0] w_mask_next;
  logic [IDX_W-1:0]   w_first_next;

  // Coordinate storage is intentionally not reset; only valid bits are.
  always_ff @(posedge clk) begin
    if (tri_we && r_state == ST_IDLE) begin
      for (int k = 0; k < NUM_TRI; k++) begin
        if (tri_waddr == IDX_W'(k)) r_table[k] <= tri_wdata;
      end
    end
  end

  // Clear first, then set, so clr+we leaves only the written entry valid.
  always_comb begin
    w_ent_vld_next = tri_clr ? '0 : r_ent_vld;
    if (tri_we) begin
      for (int k = 0; k < NUM_TRI; k++) begin
        if (tri_waddr == IDX_W'(k)) w_ent_vld_next[k] = 1'b1;
      end
    end
  end

  assign w_entry = r_table[r_idx];

  generate
    for (genvar g = 0; g < NUM_VERTS; g++) begin : g_vert
      assign w_vx[g] = w_entry[tri_field_lsb(2*g,   COORD_W) +: COORD_W];
      assign w_vy[g] = w_entry[tri_field_lsb(2*g+1, COORD_W) +: COORD_W];
    end

    // Edges (P1,P2), (P2,P3), (P3,P1).
    for (genvar g = 0; g < NUM_VERTS; g++) begin : g_edge
      tri_edge_eval #(
        .COORD_W (COORD_W)
      ) u_edge (
        .clk  (clk),
        .i_px (r_qx),
        .i_py (r_qy),
        .i_ax (w_vx[g]),
        .i_ay (w_vy[g]),
        .i_bx (w_vx[(g+1) % NUM_VERTS]),
        .i_by (w_vy[(g+1) % NUM_VERTS]),
        .o_e  (w_e[g])
      );
      assign w_neg[g]  = w_e[g][EDGE_W-1];
      assign w_zero[g] = (w_e[g] == '0);
      assign w_pos[g]  = ~w_neg[g] & ~w_zero[g];
    end
  endgenerate

`ifdef TRI_EDGE_EXCL_EN
  assign w_geom_hit = (&w_pos) | (&w_neg);
`else
  // All three zero only happens for a zero-area triangle (the edge values
  // sum to twice the signed area), which must never report a hit.
  assign w_geom_hit = ((&(w_pos | w_zero)) | (&(w_neg | w_zero))) & ~(&w_zero);
`endif

  assign w_hit = w_geom_hit & r_s2_ev;

  always_comb begin
    w_mask_next = r_hit_mask;
    for (int k = 0; k < NUM_TRI; k++) begin
      if (r_s2_idx == IDX_W'(k)) w_mask_next[k] = w_hit;
    end
  end

  always_comb begin
    w_first_next = '0;
    for (int k = NUM_TRI - 1; k >= 0; k--) begin
      if (w_mask_next[k]) w_first_next = IDX_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      q_ready    <= 1'b1;
      busy       <= 1'b0;
      r_valid    <= 1'b0;
      r_hit_mask <= '0;
      r_any      <= 1'b0;
      r_first    <= '0;
      r_ent_vld  <= '0;
      r_qx       <= '0;
      r_qy       <= '0;
      r_idx      <= '0;
      r_issuing  <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_ev    <= 1'b0;
      r_s1_idx   <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_ev    <= 1'b0;
      r_s2_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ent_vld <= w_ent_vld_next;
          r_s1_vld  <= 1'b0;
          r_s2_vld  <= 1'b0;
          if (q_valid) begin
            r_state    <= ST_SCAN;
            q_ready    <= 1'b0;
            busy       <= 1'b1;
            r_qx       <= q_x;
            r_qy       <= q_y;
            r_idx      <= '0;
            r_issuing  <= 1'b1;
            r_hit_mask <= '0;
          end
        end

        ST_SCAN: begin
          r_s1_vld <= r_issuing;
          r_s1_idx <= r_idx;
          r_s1_ev  <= r_ent_vld[r_idx];
          if (r_issuing) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) r_issuing <= 1'b0;
          end
          r_s2_vld <= r_s1_vld;
          r_s2_idx <= r_s1_idx;
          r_s2_ev  <= r_s1_ev;
          if (r_s2_vld) begin
            r_hit_mask <= w_mask_next;
            if (r_s2_idx == LAST_IDX) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_any   <= |w_mask_next;
              r_first <= w_first_next;
            end
          end
        end

        ST_DONE: begin
          if (r_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            q_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          q_ready <= 1'b1;
          busy    <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : tri_hit_scanner

`default_nettype wire

// File: tb/tb_tri_hit_scanner.sv
// ============================================================================
//  Module      : tb_tri_hit_scanner
//  Description : Directed self-checking bench for tri_hit_scanner
//                (COORD_W=12, NUM_TRI=4). Expectations follow
//                TRI_EDGE_EXCL_EN where edge points matter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tri_hit_scanner;

  localparam int CW = 12;
  localparam int NT = 4;
  localparam int IW = 2;
  localparam int LAT = NT + 2;

  logic            clk;
  logic            rst;
  logic            tri_we;
  logic [IW-1:0]   tri_waddr;
  logic [6*CW-1:0] tri_wdata;
  logic            tri_clr;
  logic            q_valid;
  logic            q_ready;
  logic [CW-1:0]   q_x;
  logic [CW-1:0]   q_y;
  logic            r_valid;
  logic            r_ready;
  logic [NT-1:0]   r_hit_mask;
  logic            r_any;
  logic [IW-1:0]   r_first;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  tri_hit_scanner #(
    .COORD_W (CW),
    .NUM_TRI (NT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tri_we     (tri_we),
    .tri_waddr  (tri_waddr),
    .tri_wdata  (tri_wdata),
    .tri_clr    (tri_clr),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_x        (q_x),
    .q_y        (q_y),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_hit_mask (r_hit_mask),
    .r_any      (r_any),
    .r_first    (r_first),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6*CW-1:0] pack_tri(input int x1, input int y1,
                                               input int x2, input int y2,
                                               input int x3, input int y3);
    return {CW'(x1), CW'(y1), CW'(x2), CW'(y2), CW'(x3), CW'(y3)};
  endfunction

  logic [6*CW-1:0] T0, T1, T2, TDEG, TFAR, TBIG;

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic write_tri(input int idx, input logic [6*CW-1:0] d);
    tri_we = 1'b1; tri_waddr = IW'(idx); tri_wdata = d;
    @(posedge clk); #1;
    tri_we = 1'b0;
  endtask

  task automatic run_query(input int x, input int y, output logic [NT-1:0] m,
                           output logic a, output logic [IW-1:0] f, output int lat);
    int cnt;
    q_x = CW'(x); q_y = CW'(y); q_valid = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0; tri_we = 1'b0; tri_clr = 1'b0;
    cnt = 0;
    while (!r_valid && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    m = r_hit_mask; a = r_any; f = r_first; lat = cnt;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (q_ready !== 1'b1) $display("FAIL reset_q_ready: got %b want 1", q_ready); else n_pass++;
    n_checks++; if (r_valid !== 1'b0) $display("FAIL reset_r_valid: got %b want 0", r_valid); else n_pass++;
    n_checks++; if (r_hit_mask !== 4'b0000) $display("FAIL reset_mask: got %b want 0000", r_hit_mask); else n_pass++;
    n_checks++; if (r_any !== 1'b0 || r_first !== 2'd0)
      $display("FAIL reset_any_first: got %b/%0d want 0/0", r_any, r_first); else n_pass++;
  endtask

  task automatic test_basic();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    write_tri(0, T0); write_tri(1, T1); write_tri(2, T2);
    run_query(0, 0, m, a, f, lat);
    n_checks++; if (lat !== LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_checks++; if (m !== 4'b0001) $display("FAIL basic_p00_mask: got %b want 0001", m); else n_pass++;
    n_checks++; if (a !== 1'b1 || f !== 2'd0) $display("FAIL basic_p00_any_first: got %b/%0d want 1/0", a, f); else n_pass++;
    run_query(-14, 12, m, a, f, lat);
    n_checks++; if (m !== 4'b0100) $display("FAIL basic_p1412_mask: got %b want 0100", m); else n_pass++;
    n_checks++; if (a !== 1'b1 || f !== 2'd2) $display("FAIL basic_p1412_any_first: got %b/%0d want 1/2", a, f); else n_pass++;
    run_query(-3, 3, m, a, f, lat);
    n_checks++; if (m !== 4'b0000) $display("FAIL basic_p33_mask: got %b want 0000", m); else n_pass++;
    n_checks++; if (a !== 1'b0 || f !== 2'd0) $display("FAIL basic_p33_any_first: got %b/%0d want 0/0", a, f); else n_pass++;
  endtask

  task automatic test_first();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    write_tri(3, T2);
    run_query(-14, 12, m, a, f, lat);
    n_checks++; if (m !== 4'b1100) $display("FAIL first_mask: got %b want 1100", m); else n_pass++;
    n_checks++; if (f !== 2'd2) $display("FAIL first_index: got %0d want 2", f); else n_pass++;
  endtask

  task automatic test_edge_point();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    logic [NT-1:0] exp_m;
`ifdef TRI_EDGE_EXCL_EN
    exp_m = 4'b0000;
`else
    exp_m = 4'b0001;
`endif
    run_query(3, 0, m, a, f, lat);
    n_checks++; if (m !== exp_m) $display("FAIL edge_point_mask: got %b want %b", m, exp_m); else n_pass++;
    n_checks++; if (a !== |exp_m) $display("FAIL edge_point_any: got %b want %b", a, |exp_m); else n_pass++;
  endtask

  task automatic test_degenerate();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    write_tri(1, TDEG);
    run_query(1, 1, m, a, f, lat);
    n_checks++; if (m !== 4'b0001) $display("FAIL degenerate_mask: got %b want 0001", m); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    int cnt;
    q_x = '0; q_y = '0; q_valid = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || q_ready !== 1'b0)
      $display("FAIL scan_busy_qready: got %b/%b want 1/0", busy, q_ready); else n_pass++;
    // Attempt to overwrite entry0 and clear the table while scanning.
    tri_we = 1'b1; tri_waddr = 2'd0; tri_wdata = TFAR; tri_clr = 1'b1;
    @(posedge clk); #1;
    tri_we = 1'b0; tri_clr = 1'b0;
    cnt = 1;
    while (!r_valid && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    n_checks++; if (cnt !== LAT) $display("FAIL bp_latency: got %0d want %0d", cnt, LAT); else n_pass++;
    tri_we = 1'b1; tri_waddr = 2'd0; tri_wdata = TFAR;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (r_valid !== 1'b1 || r_hit_mask !== 4'b0001 || r_any !== 1'b1 || r_first !== 2'd0 || q_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got v=%b m=%b a=%b f=%0d qr=%b want v=1 m=0001 a=1 f=0 qr=0",
                 i, r_valid, r_hit_mask, r_any, r_first, q_ready);
      else n_pass++;
    end
    tri_we = 1'b0;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    n_checks++; if (r_valid !== 1'b0 || q_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL bp_release: got v=%b qr=%b busy=%b want 0/1/0", r_valid, q_ready, busy); else n_pass++;
    run_query(0, 0, m, a, f, lat);
    n_checks++; if (m !== 4'b0001) $display("FAIL bp_table_unchanged: got %b want 0001", m); else n_pass++;
  endtask

  task automatic test_write_accept_same_cycle();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    tri_we = 1'b1; tri_waddr = 2'd1; tri_wdata = T0;
    run_query(0, 0, m, a, f, lat);
    n_checks++; if (m !== 4'b0011) $display("FAIL same_cycle_write_mask: got %b want 0011", m); else n_pass++;
  endtask

  task automatic test_clr_with_write();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    tri_clr = 1'b1;
    write_tri(2, T0);
    tri_clr = 1'b0;
    run_query(0, 0, m, a, f, lat);
    n_checks++; if (m !== 4'b0100) $display("FAIL clr_we_mask: got %b want 0100", m); else n_pass++;
    n_checks++; if (f !== 2'd2) $display("FAIL clr_we_first: got %0d want 2", f); else n_pass++;
    tri_clr = 1'b1;
    @(posedge clk); #1;
    tri_clr = 1'b0;
    run_query(0, 0, m, a, f, lat);
    n_checks++; if (m !== 4'b0000 || a !== 1'b0) $display("FAIL clr_only: got %b/%b want 0000/0", m, a); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    logic seen;
    write_tri(0, T0);
    q_x = '0; q_y = '0; q_valid = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || q_ready !== 1'b1 || r_valid !== 1'b0)
      $display("FAIL midscan_reset_state: got busy=%b qr=%b v=%b want 0/1/0", busy, q_ready, r_valid); else n_pass++;
    n_checks++; if (r_hit_mask !== 4'b0000 || r_any !== 1'b0 || r_first !== 2'd0)
      $display("FAIL midscan_reset_result: got %b/%b/%0d want 0000/0/0", r_hit_mask, r_any, r_first); else n_pass++;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (r_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL midscan_stale_result: got %b want 0", seen); else n_pass++;
    run_query(0, 0, m, a, f, lat);
    n_checks++; if (m !== 4'b0000 || lat !== LAT)
      $display("FAIL midscan_requery: got %b lat %0d want 0000 lat %0d", m, lat, LAT); else n_pass++;
  endtask

  task automatic test_extreme();
    logic [NT-1:0] m; logic a; logic [IW-1:0] f; int lat;
    logic [NT-1:0] exp_m;
    write_tri(0, TBIG);
    run_query(-2000, -2000, m, a, f, lat);
    n_checks++; if (m !== 4'b0001) $display("FAIL extreme_inside: got %b want 0001", m); else n_pass++;
    run_query(2047, 2047, m, a, f, lat);
    n_checks++; if (m !== 4'b0000) $display("FAIL extreme_outside: got %b want 0000", m); else n_pass++;
`ifdef TRI_EDGE_EXCL_EN
    exp_m = 4'b0000;
`else
    exp_m = 4'b0001;
`endif
    run_query(-2048, -2048, m, a, f, lat);
    n_checks++; if (m !== exp_m) $display("FAIL extreme_vertex: got %b want %b", m, exp_m); else n_pass++;
  endtask

  initial begin
    T0   = pack_tri(-6, -1, 3, 3, 3, -3);
    T1   = pack_tri(20, -2, -1, 8, 20, 12);
    T2   = pack_tri(-17, -4, 5, 15, -43, 20);
    TDEG = pack_tri(0, 0, 2, 2, 4, 4);
    TFAR = pack_tri(100, 100, 110, 100, 100, 110);
    TBIG = pack_tri(-2048, -2048, 2047, -2048, -2048, 2047);
    rst = 1'b1; tri_we = 1'b0; tri_waddr = '0; tri_wdata = '0; tri_clr = 1'b0;
    q_valid = 1'b0; q_x = '0; q_y = '0; r_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_first();
    test_edge_point();
    test_degenerate();
    test_backpressure();
    test_write_accept_same_cycle();
    test_clr_with_write();
    test_reset_mid_scan();
    test_extreme();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tri_hit_scanner

`default_nettype wire
